// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer on the M-stage data bus.
// Word map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
// irq is pending gated by the IM bit, driven from flops through a single AND.
module timer_dev #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e             state_q;
  logic [3:0]         ctrl_q;
  logic [CNT_W-1:0]   preset_q;
  logic [CNT_W-1:0]   count_q;
  logic               pending_q;

  logic en;
  logic auto_reload;
  logic expire;
  logic ctrl_wr;
  logic preset_wr;

  assign en          = ctrl_q[0];
  // MODE 1x falls back to one-shot, so only 01 reloads.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  // True on the edge where the FSM moves CNT -> INT; COUNT of 0 counts as 1.
  assign expire      = (state_q == StCnt) && en && (count_q <= CNT_W'(1));
  assign ctrl_wr     = we && (addr == 2'd0);
  assign preset_wr   = we && (addr == 2'd1);

  // Counter FSM and COUNT register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) state_q <= StLoad;
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            count_q <= '0;
            state_q <= StInt;
          end
        end
        StInt: begin
          state_q <= auto_reload ? StLoad : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Software-visible CTRL and PRESET; a CTRL store overrides the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= wdata[3:0];
      end else if ((state_q == StInt) && !auto_reload) begin
        ctrl_q[0] <= 1'b0;
      end
      if (preset_wr) preset_q <= wdata[CNT_W-1:0];
    end
  end

  // Pending flag: expiry beats a simultaneous CTRL-store clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else if (expire) begin
      pending_q <= 1'b1;
    end else if (ctrl_wr) begin
      pending_q <= 1'b0;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = {28'b0, ctrl_q};
      2'd1:    rdata = 32'(preset_q);
      2'd2:    rdata = 32'(count_q);
      default: rdata = '0;
    endcase
  end

  assign irq = pending_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev; edges are counted from the CTRL store (E0).
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_tests;
  int unsigned n_fail;

  timer_dev #(.CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_eq(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;

    // Reset held two edges while writes are attempted.
    we    = 1'b1;
    addr  = 2'($urandom_range(0, 2));
    wdata = $urandom;
    tick();
    addr  = 2'($urandom_range(0, 2));
    wdata = $urandom;
    tick();
    we    = 1'b0;
    reset = 1'b1;
    check_reg("rst_ctrl", 2'd0, 32'h0);
    check_reg("rst_preset", 2'd1, 32'h0);
    check_reg("rst_count", 2'd2, 32'h0);
    check_reg("rst_rsvd", 2'd3, 32'h0);
    check_irq("rst_irq", 1'b0);

    // One-shot, PRESET=5: COUNT 5..0 over E2..E7, INT at E7.
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    ticks(2);
    check_reg("os_cnt_e2", 2'd2, 32'd5);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check_reg($sformatf("os_cnt_e%0d", k), 2'd2, 32'(7 - k));
      if (k == 6) check_irq("os_irq_e6", 1'b0);
    end
    check_irq("os_irq_e7", 1'b1);
    tick();
    check_reg("os_ctrl_en_clr", 2'd0, 32'h8);
    check_irq("os_irq_held", 1'b1);
    bus_write(2'd0, 32'h0);
    check_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET=3: INT entries at E5, E10, E15.
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 4) check_irq("ar_irq_e4", 1'b0);
      if (k == 5 || k == 10 || k == 15) begin
        check_reg($sformatf("ar_cnt0_e%0d", k), 2'd2, 32'd0);
        check_irq($sformatf("ar_irq_e%0d", k), 1'b1);
      end
      if (k == 7 || k == 12) check_reg($sformatf("ar_reload_e%0d", k), 2'd2, 32'd3);
      if (k == 8) check_irq("ar_irq_held_e8", 1'b1);
    end
    check_reg("ar_ctrl_kept", 2'd0, 32'hB);
    bus_write(2'd0, 32'h0);
    check_irq("ar_irq_clr", 1'b0);
    ticks(3);

    // Masked expiry: pending sets but irq stays low, then a CTRL store clears it.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    ticks(4);
    check_reg("mk_cnt_e4", 2'd2, 32'd0);
    check_irq("mk_irq_e4", 1'b0);
    tick();
    bus_write(2'd0, 32'h8);
    check_irq("mk_irq_after_clr", 1'b0);
    ticks(2);
    check_irq("mk_irq_later", 1'b0);

    // Abort: EN cleared by the store landing at E6, COUNT freezes at 6.
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);
    ticks(5);
    check_reg("ab_cnt_e5", 2'd2, 32'd7);
    bus_write(2'd0, 32'h8);
    ticks(3);
    check_reg("ab_cnt_hold", 2'd2, 32'd6);
    check_irq("ab_irq", 1'b0);
    check_reg("ab_ctrl", 2'd0, 32'h8);

    // Restart, then reset when COUNT=4 (E8).
    bus_write(2'd0, 32'h9);
    ticks(8);
    check_reg("rs_cnt_e8", 2'd2, 32'd4);
    pulse_reset();
    check_reg("rs_ctrl", 2'd0, 32'h0);
    check_reg("rs_preset", 2'd1, 32'h0);
    check_reg("rs_count", 2'd2, 32'h0);
    ticks(12);
    check_irq("rs_irq_later", 1'b0);
    check_reg("rs_count_later", 2'd2, 32'h0);

    // PRESET=0 behaves as 1: INT at E3.
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    ticks(2);
    check_irq("p0_irq_e2", 1'b0);
    tick();
    check_irq("p0_irq_e3", 1'b1);
    bus_write(2'd0, 32'h0);
    ticks(2);

    // CTRL store on the INT-entry edge (E4) and on the EN-clear edge (E5).
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    ticks(3);
    bus_write(2'd0, 32'h9);
    check_reg("co_ctrl_e4", 2'd0, 32'h9);
    check_irq("co_pending_e4", 1'b1);
    bus_write(2'd0, 32'hD);
    check_reg("co_ctrl_sw_wins", 2'd0, 32'hD);
    check_irq("co_irq_e5", 1'b0);

    // Stores to COUNT and to the reserved word are dropped.
    pulse_reset();
    bus_write(2'd1, 32'd7);
    bus_write(2'd2, 32'h55);
    bus_write(2'd3, 32'hFFFF_FFFF);
    check_reg("ro_count", 2'd2, 32'h0);
    check_reg("ro_rsvd", 2'd3, 32'h0);
    check_reg("ro_ctrl", 2'd0, 32'h0);
    check_reg("ro_preset", 2'd1, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped down-counting timer on the CPU's data-memory bus, downstream of the memory stage. The M-stage address decoder drives it alongside `dm`: a store writes a timer register, and a load returns one through `rdata`. It raises `irq` when the count expires, either once (one-shot) or periodically (auto-reload).

## Interface
- CNT_W, 32, width of PRESET and COUNT; `rdata` zero-extends to 32 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- we  input  1  write strobe from the M stage (store decoded to timer range).
- addr  input  2  word index (bus address [3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- wdata  input  32  store data.
- rdata  output  32  read data for `addr`; combinational from registers.
- irq  output  1  interrupt request = pending & CTRL[3]; driven only from flops and one AND gate.

## Operation
- Registers:
  - CTRL[3:0]: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask). CTRL[31:4] reads 0.
  - PRESET: read/write.
  - COUNT: read-only; writes are ignored.
  - Reserved address: reads 0; writes are ignored.
- Pending flag:
  - Set on the edge where the FSM enters INT.
  - Cleared by any CTRL write.
  - If set and clear occur on the same edge, set wins.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: go to IDLE; COUNT holds.
  - CNT, EN=1, COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1, COUNT<=1: COUNT <= 0; go to INT.
  - INT, MODE=00: hardware clears EN; go to IDLE.
  - INT, MODE=01: go to LOAD (EN is not touched).
- A PRESET write during CNT does not affect the running count; it is used at the next LOAD.
- A CTRL write on the same edge as the INT hardware EN clear: the software value wins.
- Reset (reset=0 at an edge): CTRL, PRESET and COUNT = 0; state IDLE; pending 0.
  - Hence irq=0 and rdata=0 for every addr.
  - Reset mid-count aborts immediately; no irq is produced.

## Timing
- Register writes take effect at the edge where `we`=1. `rdata` reflects the new value in the following cycle.
- `rdata` has zero read latency (same cycle as `addr`), matching M-stage load timing.
- One-shot, CTRL written with EN=1 at edge E0 and PRESET=P≥1:
  - E1: LOAD.
  - E2: COUNT=P, CNT.
  - COUNT reaches 0 and the FSM enters INT at E(P+2).
  - `irq` rises after E(P+2) if IM=1.
- PRESET=0 behaves as PRESET=1: INT is entered at E3.
- Auto-reload period: P+2 edges between successive INT entries (INT → LOAD → CNT ×P).
- `irq` stays high until a CTRL write clears pending. Auto-reload expiries while pending is set keep it set.
- Clearing EN by write during CNT: the FSM is in IDLE after the next edge; COUNT freezes at its current value.

## Test plan
- Reset: drive reset=0 for 2 edges with we=1, random data → rdata=0 at all addr, irq=0, COUNT=0.
- One-shot: PRESET=5, CTRL=0x9 at E0 → COUNT reads 5,4,3,2,1,0 over E2..E7; irq=1 from E7; CTRL reads 0x8 (EN cleared); a CTRL write of 0x0 drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → INT entries at E5, E10, E15; COUNT reloads to 3 after each; irq stays high until a CTRL write.
- Mask: PRESET=2, CTRL=0x1 → counter expires, irq stays 0; a later write CTRL=0x8 clears pending, irq stays 0.
- Abort and reset: CTRL=0x9, PRESET=10; at COUNT=6 write CTRL=0x8 → COUNT holds at 6, no irq. Restart, then drop reset at COUNT=4 → all registers 0, irq 0.
- Edge cases:
  - PRESET=0 → INT entered at E3.
  - CTRL write coinciding with INT entry → CTRL takes the written value and pending=1.
  - Writes to COUNT or addr 3 → no effect; addr 3 reads 0.
